// File: rtl/uart_phy_if.sv
// Byte-side and line-side signal bundle for uart_phy.
// The PHY uses the slave view; the upstream peripheral or a bench uses the master view.
interface uart_phy_if;
  logic       RX;
  logic       TX;
  logic       send_data;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       tx_busy;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       frame_err;

  modport slave (
    input  RX, send_data, tx_data,
    output TX, tx_done, tx_busy, rx_done, rx_data, frame_err
  );

  modport master (
    output RX, send_data, tx_data,
    input  TX, tx_done, tx_busy, rx_done, rx_data, frame_err
  );
endinterface

// File: rtl/uart_phy.sv
// 8N1 UART transceiver at a fixed baud: independent TX and RX FSMs,
// a 2-flop RX synchronizer, start-bit glitch rejection and stop-bit check.
module uart_phy #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_phy_if.slave  bus
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / UART_BPS;
  localparam int unsigned CW       = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------- TX
  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]    tx_bit_q,   tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line;
  logic          tx_done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_c  = 1'b0;
    unique case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (bus.send_data) begin
          tx_shift_d = bus.tx_data;
          tx_bit_d   = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_done_c  = 1'b1;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Line decoded from state flops, so an async reset returns TX high at once.
  always_comb begin
    tx_line = 1'b1;
    unique case (tx_state_q)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_shift_q[0];
      default: tx_line = 1'b1;
    endcase
  end

  assign bus.TX      = tx_line;
  assign bus.tx_busy = (tx_state_q != S_IDLE);
  assign bus.tx_done = tx_done_c;

  // ---------------------------------------------------------------- RX
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]    rx_bit_q,   rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q,  rx_data_d;
  logic          rx_done_q,  rx_done_d;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s_q) rx_state_d = S_START;
      end
      S_START: begin
        // Half-bit check: after this, every sample lands on a bit centre.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_s_q) begin
            rx_data_d = rx_shift_q;
            rx_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_phy.sv
// Directed-plus-random bench for uart_phy, checked against a frame-level UART model.
module tb_uart_phy;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned UART_BPS = 100_000;
  localparam int BD = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loop_en = 1'b0;
  logic rx_drv = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int ferr_cnt = 0;
  int last_rx_cyc = 0;
  logic [7:0] rx_log[$];

  uart_phy_if ifc();

  assign ifc.RX = loop_en ? ifc.TX : rx_drv;

  uart_phy #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifc.tx_done === 1'b1) tx_done_cnt <= tx_done_cnt + 1;
    if (ifc.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (ifc.rx_done === 1'b1) begin
      rx_done_cnt <= rx_done_cnt + 1;
      last_rx_cyc <= cyc;
      rx_log.push_back(ifc.rx_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmit one byte and compare every cycle of the line against the 8N1 frame.
  // inject_at>0 raises send_data with junk on that cycle of the frame.
  task automatic send_frame(input logic [7:0] b, input int inject_at, input logic [7:0] junk,
                            input string tag);
    logic [9:0] fr;
    int bad_tx, bad_busy, bad_done, d0;
    fr = {1'b1, b, 1'b0};
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    d0 = tx_done_cnt;
    ifc.send_data = 1'b1;
    ifc.tx_data = b;
    for (int k = 1; k <= 10 * BD; k++) begin
      tick();
      if (k == 1 || k == inject_at + 1) ifc.send_data = 1'b0;
      if (k == inject_at) begin
        ifc.send_data = 1'b1;
        ifc.tx_data = junk;
      end
      if (ifc.TX !== fr[(k - 1) / BD]) bad_tx++;
      if (ifc.tx_busy !== 1'b1) bad_busy++;
      if (ifc.tx_done !== (k == 10 * BD)) bad_done++;
    end
    tick();
    ifc.send_data = 1'b0;
    chk({tag, "_tx_wave"}, bad_tx, 0);
    chk({tag, "_busy_wave"}, bad_busy, 0);
    chk({tag, "_done_wave"}, bad_done, 0);
    chk({tag, "_idle_busy"}, {31'b0, ifc.tx_busy}, 0);
    chk({tag, "_idle_tx"}, {31'b0, ifc.TX}, 1);
    chk({tag, "_done_count"}, tx_done_cnt - d0, 1);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (BD) tick();
    end
  endtask

  initial begin
    int r0, f0, t0, start, bad, base, lat;
    logic [7:0] exp_b[6];

    ifc.send_data = 1'b0;
    ifc.tx_data = '0;
    rx_drv = 1'b1;
    repeat (3) tick();
    chk("rst_TX", {31'b0, ifc.TX}, 1);
    chk("rst_tx_busy", {31'b0, ifc.tx_busy}, 0);
    chk("rst_tx_done", {31'b0, ifc.tx_done}, 0);
    chk("rst_rx_done", {31'b0, ifc.rx_done}, 0);
    chk("rst_rx_data", {24'b0, ifc.rx_data}, 0);
    chk("rst_frame_err", {31'b0, ifc.frame_err}, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // TX basic frame
    send_frame(8'hA5, 0, 8'h00, "s1");
    repeat (5) tick();

    // Busy reject mid-frame, then confirm no second frame follows
    send_frame(8'hA5, 40, 8'h00, "s2");
    t0 = tx_done_cnt;
    bad = 0;
    repeat (120) begin
      tick();
      if (ifc.TX !== 1'b1 || ifc.tx_busy !== 1'b0) bad++;
    end
    chk("s2_no_second_frame", bad, 0);
    chk("s2_no_extra_done", tx_done_cnt - t0, 0);

    // send_data on the tx_done cycle is ignored
    send_frame(8'($urandom), 10 * BD, 8'($urandom), "done_cycle");
    bad = 0;
    repeat (30) begin
      tick();
      if (ifc.tx_busy !== 1'b0) bad++;
    end
    chk("done_cycle_ignored", bad, 0);

    for (int n = 0; n < 3; n++) send_frame(8'($urandom), 0, 8'h00, $sformatf("rtx%0d", n));

    // RX at exact baud
    r0 = rx_done_cnt; f0 = ferr_cnt;
    start = cyc;
    drive_rx(8'h3C, 1'b1);
    repeat (5) tick();
    lat = last_rx_cyc - start;
    chk("s3_rx_count", rx_done_cnt - r0, 1);
    chk("s3_rx_data", {24'b0, ifc.rx_data}, 32'h3C);
    chk("s3_no_ferr", ferr_cnt - f0, 0);
    chk("s3_latency_window", {31'b0, (lat >= 96 && lat <= 99)}, 1);

    // Bad stop bit keeps the previous byte
    r0 = rx_done_cnt; f0 = ferr_cnt;
    drive_rx(8'hFF, 1'b0);
    rx_drv = 1'b1;
    repeat (20) tick();
    chk("s5_ferr_count", ferr_cnt - f0, 1);
    chk("s5_no_rx_done", rx_done_cnt - r0, 0);
    chk("s5_rx_data_held", {24'b0, ifc.rx_data}, 32'h3C);

    // Break: one frame_err, then silence until the line rises
    r0 = rx_done_cnt; f0 = ferr_cnt;
    rx_drv = 1'b0;
    repeat (300) tick();
    rx_drv = 1'b1;
    repeat (30) tick();
    chk("break_ferr_count", ferr_cnt - f0, 1);
    chk("break_no_rx_done", rx_done_cnt - r0, 0);

    // Start-bit glitch, then a valid frame
    r0 = rx_done_cnt; f0 = ferr_cnt;
    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    repeat (20) tick();
    chk("s4_glitch_silent", (rx_done_cnt - r0) + (ferr_cnt - f0), 0);
    drive_rx(8'h81, 1'b1);
    repeat (10) tick();
    chk("s4_rx_count", rx_done_cnt - r0, 1);
    chk("s4_rx_data", {24'b0, ifc.rx_data}, 32'h81);
    chk("s4_no_ferr", ferr_cnt - f0, 0);

    // Random back-to-back frames with zero idle time
    r0 = rx_done_cnt; f0 = ferr_cnt;
    base = rx_log.size();
    for (int n = 0; n < 6; n++) begin
      exp_b[n] = 8'($urandom);
      drive_rx(exp_b[n], 1'b1);
    end
    repeat (10) tick();
    chk("rrx_count", rx_done_cnt - r0, 6);
    chk("rrx_no_ferr", ferr_cnt - f0, 0);
    for (int n = 0; n < 6; n++)
      if (base + n < rx_log.size())
        chk($sformatf("rrx_byte%0d", n), {24'b0, rx_log[base + n]}, {24'b0, exp_b[n]});
      else
        chk($sformatf("rrx_byte%0d_missing", n), 0, 1);

    // Loopback, back-to-back transmissions
    loop_en = 1'b1;
    repeat (5) tick();
    r0 = rx_done_cnt;
    base = rx_log.size();
    send_frame(8'h55, 0, 8'h00, "lb0");
    send_frame(8'hAA, 0, 8'h00, "lb1");
    repeat (20) tick();
    chk("lb_rx_count", rx_done_cnt - r0, 2);
    if (base + 1 < rx_log.size()) begin
      chk("lb_byte0", {24'b0, rx_log[base]}, 32'h55);
      chk("lb_byte1", {24'b0, rx_log[base + 1]}, 32'hAA);
    end else begin
      chk("lb_bytes_missing", 0, 1);
    end

    // Reset mid-frame aborts both directions
    t0 = tx_done_cnt; r0 = rx_done_cnt; f0 = ferr_cnt;
    ifc.send_data = 1'b1;
    ifc.tx_data = 8'($urandom);
    tick();
    ifc.send_data = 1'b0;
    repeat (44) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_TX_high", {31'b0, ifc.TX}, 1);
    chk("abort_busy_low", {31'b0, ifc.tx_busy}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (150) tick();
    chk("abort_no_tx_done", tx_done_cnt - t0, 0);
    chk("abort_no_rx_done", rx_done_cnt - r0, 0);
    chk("abort_no_ferr", ferr_cnt - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
